// File: rtl/rv_mem_arb_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package rv_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // Counter width able to hold 0..max_streak inclusive.
    function automatic int unsigned streak_w(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/rv_mem_arb_if.sv
// Fetch, LSU and external bus signals seen by the memory arbiter.
interface rv_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              i_instr_req;
    logic [ADDR_W-1:0] i_instr_addr;
    logic              i_instr_flush;
    logic              o_instr_ack;
    logic [DATA_W-1:0] o_instr_data;

    logic              i_data_req;
    logic [ADDR_W-1:0] i_data_addr;
    logic              i_data_we;
    logic [DATA_W-1:0] i_data_wdata;
    logic [SEL_W-1:0]  i_data_sel;
    logic              o_data_ack;
    logic [DATA_W-1:0] o_data_rdata;

    logic              o_bus_req;
    logic [ADDR_W-1:0] o_bus_addr;
    logic              o_bus_we;
    logic [DATA_W-1:0] o_bus_wdata;
    logic [SEL_W-1:0]  o_bus_sel;
    logic              i_bus_ack;
    logic [DATA_W-1:0] i_bus_rdata;

    // Arbiter side.
    modport slave (
        input  i_instr_req, i_instr_addr, i_instr_flush,
        output o_instr_ack, o_instr_data,
        input  i_data_req, i_data_addr, i_data_we, i_data_wdata, i_data_sel,
        output o_data_ack, o_data_rdata,
        output o_bus_req, o_bus_addr, o_bus_we, o_bus_wdata, o_bus_sel,
        input  i_bus_ack, i_bus_rdata
    );

    // Pipeline stages plus external slave.
    modport master (
        output i_instr_req, i_instr_addr, i_instr_flush,
        input  o_instr_ack, o_instr_data,
        output i_data_req, i_data_addr, i_data_we, i_data_wdata, i_data_sel,
        input  o_data_ack, o_data_rdata,
        input  o_bus_req, o_bus_addr, o_bus_we, o_bus_wdata, o_bus_sel,
        output i_bus_ack, i_bus_rdata
    );

endinterface

// File: rtl/rv_mem_arb_prio.sv
// Grant decision for the idle arbiter: data first, with a streak counter
// that forces a fetch grant after MAX_D_STREAK data grants while fetch waits.
module rv_mem_arb_prio
    import rv_mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic idle,
    input  logic instr_req,
    input  logic instr_flush,
    input  logic data_req,
    output logic grant_i,
    output logic grant_d
);
    localparam int SW = streak_w(MAX_D_STREAK);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;
    logic          instr_eligible;

    assign instr_eligible = instr_req & ~instr_flush;
    assign grant_d = idle & data_req & (~instr_eligible | (streak < MAX_S));
    assign grant_i = idle & ~grant_d & instr_eligible;

    // A data grant counts toward the streak whenever fetch is asking at all,
    // even if a flush kept it ineligible this cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!instr_req)
                streak <= '0;
            else if (streak != MAX_S)
                streak <= streak + 1'b1;
        end else if (grant_i) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/rv_mem_arb.sv
// Single-outstanding arbiter sharing the memory bus between fetch and LSU.
// Bus fields are registered at grant and held until the slave acks.
module rv_mem_arb
    import rv_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    rv_mem_arb_if.slave  m
);
    localparam int SEL_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } mem_req_t;

    arb_state_t state;
    mem_req_t   breq;
    logic       bus_req;
    logic       drop;
    logic       grant_i;
    logic       grant_d;

    rv_mem_arb_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .idle       (state == ARB_IDLE),
        .instr_req  (m.i_instr_req),
        .instr_flush(m.i_instr_flush),
        .data_req   (m.i_data_req),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ARB_IDLE;
            bus_req <= 1'b0;
            breq    <= '0;
            drop    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state   <= ARB_BUSY_D;
                        bus_req <= 1'b1;
                        breq    <= '{addr: m.i_data_addr, we: m.i_data_we,
                                     wdata: m.i_data_wdata, sel: m.i_data_sel};
                    end else if (grant_i) begin
                        state   <= ARB_BUSY_I;
                        bus_req <= 1'b1;
                        breq    <= '{addr: m.i_instr_addr, we: 1'b0,
                                     wdata: '0, sel: '1};
                    end
                end
                ARB_BUSY_I: begin
                    // The cancelled fetch still runs to completion on the bus;
                    // only its ack back to fetch is swallowed.
                    if (m.i_bus_ack) begin
                        state   <= ARB_IDLE;
                        bus_req <= 1'b0;
                        drop    <= 1'b0;
                    end else if (m.i_instr_flush) begin
                        drop    <= 1'b1;
                    end
                end
                ARB_BUSY_D: begin
                    if (m.i_bus_ack) begin
                        state   <= ARB_IDLE;
                        bus_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign m.o_bus_req   = bus_req;
    assign m.o_bus_addr  = breq.addr;
    assign m.o_bus_we    = breq.we;
    assign m.o_bus_wdata = breq.wdata;
    assign m.o_bus_sel   = breq.sel;

    assign m.o_instr_ack  = (state == ARB_BUSY_I) & m.i_bus_ack & ~drop & ~m.i_instr_flush;
    assign m.o_data_ack   = (state == ARB_BUSY_D) & m.i_bus_ack;
    assign m.o_instr_data = m.i_bus_rdata;
    assign m.o_data_rdata = m.i_bus_rdata;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: one task per scenario, inline checks.
module tb_rv_mem_arb;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rv_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rv_mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .m      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_instr_req   = 1'b0;
        bus.i_instr_addr  = '0;
        bus.i_instr_flush = 1'b0;
        bus.i_data_req    = 1'b0;
        bus.i_data_addr   = '0;
        bus.i_data_we     = 1'b0;
        bus.i_data_wdata  = '0;
        bus.i_data_sel    = '0;
        bus.i_bus_ack     = 1'b0;
        bus.i_bus_rdata   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #2;
        checks++;
        if (bus.o_bus_req !== 1'b0 || bus.o_bus_we !== 1'b0) begin
            errors++; $display("FAIL reset_req_we got req=%b we=%b exp 0 0", bus.o_bus_req, bus.o_bus_we);
        end
        checks++;
        if (bus.o_bus_addr !== 32'h0 || bus.o_bus_wdata !== 32'h0 || bus.o_bus_sel !== 4'h0) begin
            errors++; $display("FAIL reset_fields got addr=%h wdata=%h sel=%h exp 0", bus.o_bus_addr, bus.o_bus_wdata, bus.o_bus_sel);
        end
        checks++;
        if (bus.o_instr_ack !== 1'b0 || bus.o_data_ack !== 1'b0) begin
            errors++; $display("FAIL reset_acks got i=%b d=%b exp 0 0", bus.o_instr_ack, bus.o_data_ack);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        bus.i_instr_addr = 32'h100;
        bus.i_instr_req  = 1'b1;
        #2;
        checks++;
        if (bus.o_bus_req !== 1'b0) begin
            errors++; $display("FAIL fetch_req_latency got %b exp 0", bus.o_bus_req);
        end
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h100 || bus.o_bus_we !== 1'b0 ||
            bus.o_bus_sel !== 4'hF || bus.o_bus_wdata !== 32'h0) begin
            errors++; $display("FAIL fetch_fields got req=%b addr=%h we=%b sel=%h wdata=%h exp 1 100 0 f 0",
                               bus.o_bus_req, bus.o_bus_addr, bus.o_bus_we, bus.o_bus_sel, bus.o_bus_wdata);
        end
        step();
        step(); #2;
        checks++;
        if (bus.o_instr_ack !== 1'b0 || bus.o_bus_req !== 1'b1) begin
            errors++; $display("FAIL fetch_wait got ack=%b req=%b exp 0 1", bus.o_instr_ack, bus.o_bus_req);
        end
        step();
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = 32'h13;
        #2;
        checks++;
        if (bus.o_instr_ack !== 1'b1 || bus.o_instr_data !== 32'h13 || bus.o_data_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_ack got ack=%b data=%h dack=%b exp 1 13 0",
                               bus.o_instr_ack, bus.o_instr_data, bus.o_data_ack);
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if (bus.o_bus_req !== 1'b0) begin
            errors++; $display("FAIL fetch_req_drop got %b exp 0", bus.o_bus_req);
        end
        step();
    endtask

    task automatic test_data_write();
        bus.i_data_req   = 1'b1;
        bus.i_data_addr  = 32'h2000;
        bus.i_data_we    = 1'b1;
        bus.i_data_wdata = 32'hDEADBEEF;
        bus.i_data_sel   = 4'b0011;
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h2000 || bus.o_bus_we !== 1'b1 ||
            bus.o_bus_wdata !== 32'hDEADBEEF || bus.o_bus_sel !== 4'b0011) begin
            errors++; $display("FAIL dwrite_fields got req=%b addr=%h we=%b wdata=%h sel=%h exp 1 2000 1 deadbeef 3",
                               bus.o_bus_req, bus.o_bus_addr, bus.o_bus_we, bus.o_bus_wdata, bus.o_bus_sel);
        end
        bus.i_bus_ack = 1'b1;
        #1;
        checks++;
        if (bus.o_data_ack !== 1'b1 || bus.o_instr_ack !== 1'b0) begin
            errors++; $display("FAIL dwrite_ack got d=%b i=%b exp 1 0", bus.o_data_ack, bus.o_instr_ack);
        end
        step();
        idle_inputs();
        #2;
        checks++;
        if (bus.o_bus_req !== 1'b0) begin
            errors++; $display("FAIL dwrite_req_drop got %b exp 0", bus.o_bus_req);
        end
        step();
    endtask

    task automatic test_streak();
        logic [9:0] expd;
        logic       got_d;
        expd = 10'b01111_01111;
        bus.i_instr_addr = 32'h300;
        bus.i_data_addr  = 32'h400;
        bus.i_data_sel   = 4'hF;
        bus.i_instr_req  = 1'b1;
        bus.i_data_req   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); #2;
            got_d = (bus.o_bus_addr == 32'h400);
            checks++;
            if (bus.o_bus_req !== 1'b1 || got_d !== expd[i]) begin
                errors++; $display("FAIL grant_order[%0d] got req=%b data=%b exp 1 %b", i, bus.o_bus_req, got_d, expd[i]);
            end
            bus.i_bus_ack = 1'b1;
            #1;
            checks++;
            if (bus.o_data_ack !== expd[i] || bus.o_instr_ack !== ~expd[i]) begin
                errors++; $display("FAIL grant_ack[%0d] got d=%b i=%b exp %b %b", i, bus.o_data_ack, bus.o_instr_ack, expd[i], ~expd[i]);
            end
            step();
            bus.i_bus_ack = 1'b0;
            #2;
            checks++;
            if (bus.o_bus_req !== 1'b0) begin
                errors++; $display("FAIL grant_bubble[%0d] got %b exp 0", i, bus.o_bus_req);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_flush_busy();
        bus.i_instr_addr = 32'h180;
        bus.i_instr_req  = 1'b1;
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h180) begin
            errors++; $display("FAIL flushb_grant got req=%b addr=%h exp 1 180", bus.o_bus_req, bus.o_bus_addr);
        end
        bus.i_instr_flush = 1'b1;
        bus.i_instr_addr  = 32'h200;
        step();
        bus.i_instr_flush = 1'b0;
        step();
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = 32'h55;
        #2;
        checks++;
        if (bus.o_instr_ack !== 1'b0) begin
            errors++; $display("FAIL flushb_drop got ack=%b exp 0", bus.o_instr_ack);
        end
        step();
        bus.i_bus_ack = 1'b0;
        #2;
        checks++;
        if (bus.o_bus_req !== 1'b0) begin
            errors++; $display("FAIL flushb_idle got req=%b exp 0", bus.o_bus_req);
        end
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h200) begin
            errors++; $display("FAIL flushb_refetch got req=%b addr=%h exp 1 200", bus.o_bus_req, bus.o_bus_addr);
        end
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = 32'h77;
        #1;
        checks++;
        if (bus.o_instr_ack !== 1'b1 || bus.o_instr_data !== 32'h77) begin
            errors++; $display("FAIL flushb_refetch_ack got ack=%b data=%h exp 1 77", bus.o_instr_ack, bus.o_instr_data);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_flush_ack();
        bus.i_instr_addr = 32'h240;
        bus.i_instr_req  = 1'b1;
        step();
        bus.i_bus_ack     = 1'b1;
        bus.i_bus_rdata   = 32'h99;
        bus.i_instr_flush = 1'b1;
        #2;
        checks++;
        if (bus.o_instr_ack !== 1'b0) begin
            errors++; $display("FAIL flush_coincident got ack=%b exp 0", bus.o_instr_ack);
        end
        step();
        idle_inputs();
        bus.i_instr_addr = 32'h244;
        bus.i_instr_req  = 1'b1;
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h244) begin
            errors++; $display("FAIL flush_next_grant got req=%b addr=%h exp 1 244", bus.o_bus_req, bus.o_bus_addr);
        end
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = 32'h44;
        #1;
        checks++;
        if (bus.o_instr_ack !== 1'b1 || bus.o_instr_data !== 32'h44) begin
            errors++; $display("FAIL flush_next_ack got ack=%b data=%h exp 1 44", bus.o_instr_ack, bus.o_instr_data);
        end
        step();
        idle_inputs();
        bus.i_data_req  = 1'b1;
        bus.i_data_addr = 32'h3000;
        bus.i_data_sel  = 4'hF;
        step();
        bus.i_instr_flush = 1'b1;
        step();
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = 32'hA5A5;
        #2;
        checks++;
        if (bus.o_data_ack !== 1'b1 || bus.o_data_rdata !== 32'hA5A5 || bus.o_instr_ack !== 1'b0) begin
            errors++; $display("FAIL flush_in_busy_d got d=%b rdata=%h i=%b exp 1 a5a5 0",
                               bus.o_data_ack, bus.o_data_rdata, bus.o_instr_ack);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_flush_idle();
        bus.i_instr_addr  = 32'h500;
        bus.i_instr_req   = 1'b1;
        bus.i_instr_flush = 1'b1;
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b0) begin
            errors++; $display("FAIL flush_idle_block got req=%b exp 0", bus.o_bus_req);
        end
        bus.i_instr_flush = 1'b0;
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h500) begin
            errors++; $display("FAIL flush_idle_grant got req=%b addr=%h exp 1 500", bus.o_bus_req, bus.o_bus_addr);
        end
        bus.i_bus_ack = 1'b1;
        step();
        idle_inputs();
        bus.i_bus_ack = 1'b1;
        #2;
        checks++;
        if (bus.o_instr_ack !== 1'b0 || bus.o_data_ack !== 1'b0) begin
            errors++; $display("FAIL idle_stray_ack got i=%b d=%b exp 0 0", bus.o_instr_ack, bus.o_data_ack);
        end
        step();
        bus.i_bus_ack = 1'b0;
        step();
    endtask

    task automatic test_reset_busy();
        bus.i_data_req   = 1'b1;
        bus.i_data_addr  = 32'h5000;
        bus.i_data_we    = 1'b1;
        bus.i_data_wdata = 32'h1234;
        bus.i_data_sel   = 4'hF;
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h5000) begin
            errors++; $display("FAIL rbusy_grant got req=%b addr=%h exp 1 5000", bus.o_bus_req, bus.o_bus_addr);
        end
        rst = 1'b1;
        bus.i_bus_ack = 1'b1;
        #1;
        checks++;
        if (bus.o_bus_req !== 1'b0 || bus.o_bus_addr !== 32'h0 || bus.o_bus_we !== 1'b0 ||
            bus.o_bus_wdata !== 32'h0 || bus.o_bus_sel !== 4'h0 || bus.o_data_ack !== 1'b0) begin
            errors++; $display("FAIL rbusy_async got req=%b addr=%h we=%b wdata=%h sel=%h dack=%b exp all 0",
                               bus.o_bus_req, bus.o_bus_addr, bus.o_bus_we, bus.o_bus_wdata, bus.o_bus_sel, bus.o_data_ack);
        end
        idle_inputs();
        step();
        rst = 1'b0;
        step();
        bus.i_data_req  = 1'b1;
        bus.i_data_addr = 32'h6000;
        bus.i_data_sel  = 4'hC;
        step(); #2;
        checks++;
        if (bus.o_bus_req !== 1'b1 || bus.o_bus_addr !== 32'h6000 || bus.o_bus_we !== 1'b0 || bus.o_bus_sel !== 4'hC) begin
            errors++; $display("FAIL rbusy_fresh got req=%b addr=%h we=%b sel=%h exp 1 6000 0 c",
                               bus.o_bus_req, bus.o_bus_addr, bus.o_bus_we, bus.o_bus_sel);
        end
        bus.i_bus_ack   = 1'b1;
        bus.i_bus_rdata = 32'hCAFE;
        #1;
        checks++;
        if (bus.o_data_ack !== 1'b1 || bus.o_data_rdata !== 32'hCAFE) begin
            errors++; $display("FAIL rbusy_fresh_ack got ack=%b rdata=%h exp 1 cafe", bus.o_data_ack, bus.o_data_rdata);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_data_write();
        test_streak();
        test_flush_busy();
        test_flush_ack();
        test_flush_idle();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
